cobi_interface: RTL and testbench
=================================

# cobi_interface

Host-side sequencer between the FPGA BRAMs and a chain of COBI oscillator chips.
- Programming: sweeps every weight cell address of every chip in the chain and strobes the per-chip address enable, so that chips latch weights read from a 1-cycle-latency BRAM.
- Readout: samples the chips' spin state and shifts the scan chain out bit by bit, issuing BRAM write strobes with the bit address.
- It sits between the weight/result BRAMs and the chip pins and is verified against the `cobi_network` chip model.

## Interface
- `NUM_CHIPS_PER_CHAIN`, default 2: number of chips daisy-chained per chain.
- `SCAN_CHAIN_DEPTH`, default 504*`NUM_CHIPS_PER_CHAIN`: number of scan bits per chain (derived).
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `start_prog`  in  1  programming request; rising-edge triggered.
- `ready_prog`  out  1  high when the programming sequencer is idle.
- `row_addr`  out  6  weight row address to the chips.
- `col_addr`  out  6  weight column address to the chips.
- `chip_in_chain_addr`  out  max(clog2(NUM_CHIPS_PER_CHAIN),1)  chip index; also the BRAM address MSBs.
- `addr_en`  out  NUM_CHIPS_PER_CHAIN  one-hot per-chip weight write strobe.
- `start_scan`  in  1  readout request; rising-edge triggered.
- `ready_scan`  out  1  high when the scan sequencer is idle.
- `sample_clk`  out  1  spin-capture clock to the chips.
- `scanout_clk`  out  1  scan shift clock to the chips.
- `scan_chain_out_valid`  out  1  result BRAM write enable.
- `bit_addr`  out  clog2(SCAN_CHAIN_DEPTH)  result BRAM address.

## Operation
- Two independent sequencers. They use disjoint pins and may run concurrently.
- `start_*` is edge-detected against a registered copy. A level held high for many cycles triggers exactly one run. Edges arriving while busy are ignored.

Programming FSM: IDLE → SET → WAIT → STROBE → HOLD → (next cell: SET | done: IDLE).
- SET drives the current {chip,row,col}.
- WAIT covers BRAM read latency.
- STROBE drives `addr_en` = 1<<chip.
- HOLD clears `addr_en` while keeping the addresses stable.
- Counter {chip,row,col} increments with col as LSB. Full 64×64 sweep per chip, chips 0..N-1.
- After the HOLD of cell (N-1,63,63): addresses return to 0 and the FSM goes to IDLE.

Scan FSM: IDLE → SAMP_HI(2) → SAMP_LO(2) → CAPT → SH_HI → SH_LO → CAPT …
- SAMP_HI drives `sample_clk`=1 for 2 cycles; SAMP_LO drives 0 for 2 cycles.
- CAPT asserts `scan_chain_out_valid` for one cycle with `bit_addr`=i.
- SH_HI drives `scanout_clk`=1 for one cycle; SH_LO drives 0.
- After CAPT with i = SCAN_CHAIN_DEPTH-1: no shift; return to IDLE and reset `bit_addr` to 0.

Reset (rst_n low, any time, including mid-run):
- All outputs 0 except `ready_prog`=`ready_scan`=1.
- Counters and the start edge registers clear.
- Releasing reset while `start_*` is already high does not trigger a run.

## Timing
- All outputs are registered.
- The clock edge that first samples a `start_*` rising edge moves the FSM out of IDLE; `ready_*` is low from that edge.
- Programming: 4 cycles per cell, so 4096·N·4 busy cycles (32768 for N=2).
- Weight data for a cell is valid at the chip one cycle after SET. The STROBE cycle is therefore where the chip latches it.
- Scan busy length: 4 + 3·(DEPTH-1) + 1 cycles (3026 for DEPTH=1008). `ready_scan` rises on the edge after the last CAPT.
- `bit_addr` increments strictly 0..DEPTH-1, each value exactly once with valid.
- `scanout_clk` pulses DEPTH-1 times; `sample_clk` pulses once per run.

## Structure
- `cobi_pkg`:
  - ROW_W=COL_W=6
  - BITS_PER_CHIP=504
  - chip address width function max(clog2(N),1)
  - both FSM state enums.
- Two sub-modules instantiated by `cobi_interface`: `programming` (programming FSM) and `scan_chain` (scan FSM). They share no state.
- `cobi_network` is the verification model, not synthesized.

## Test plan
- Reset: assert `rst_n`=0 → `ready_prog`=`ready_scan`=1, `addr_en`=0, `sample_clk`=`scanout_clk`=`scan_chain_out_valid`=0, `bit_addr`=0.
- Programming, N=2: pulse `start_prog` high for 50 cycles →
  - `ready_prog` low for exactly 32768 cycles;
  - first STROBE has chip 0, row 0, col 0, `addr_en`=2'b01;
  - last STROBE has chip 1, row 63, col 63, `addr_en`=2'b10;
  - 8192 strobes total, 1 run only.
- End-to-end with `cobi_network` and random weight BRAM: after programming, every chip cell weight equals the BRAM word at {chip,row,col}.
- Scan, DEPTH=1008:
  - `start_scan` → 1 `sample_clk` pulse, 1008 valid strobes with `bit_addr` 0..1007 in order, 1007 `scanout_clk` pulses;
  - `ready_scan` returns after 3026 cycles;
  - dumped BRAM matches the model's spin vector.
- Concurrent starts on the same cycle → both sequences complete with correct counts, independent of each other.
- Reset during scan at `bit_addr`=100 → outputs clear immediately; a subsequent `start_scan` restarts at `bit_addr` 0 with a full 1008-bit run.

Source files
------------

// File: rtl/cobi_pkg.sv
// Shared widths, chip-address helper and sequencer state types for the COBI host interface.
package cobi_pkg;

  localparam int unsigned ROW_W         = 6;
  localparam int unsigned COL_W         = 6;
  localparam int unsigned BITS_PER_CHIP = 504;

  function automatic int unsigned chip_addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [2:0] {
    PROG_IDLE,
    PROG_SET,
    PROG_WAIT,
    PROG_STROBE,
    PROG_HOLD
  } prog_state_e;

  typedef enum logic [2:0] {
    SCAN_IDLE,
    SCAN_SAMP_HI,
    SCAN_SAMP_LO,
    SCAN_CAPT,
    SCAN_SH_HI,
    SCAN_SH_LO
  } scan_state_e;

endpackage

// File: rtl/programming.sv
// Weight programming sequencer: sweeps {chip,row,col} and strobes the per-chip
// address enable once the 1-cycle BRAM read data has reached the chip pins.
module programming
  import cobi_pkg::*;
#(
  parameter int unsigned NUM_CHIPS_PER_CHAIN = 2,
  localparam int unsigned CHIP_W = chip_addr_w(NUM_CHIPS_PER_CHAIN)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_prog,
  output logic                           ready_prog,
  output logic [ROW_W-1:0]               row_addr,
  output logic [COL_W-1:0]               col_addr,
  output logic [CHIP_W-1:0]              chip_in_chain_addr,
  output logic [NUM_CHIPS_PER_CHAIN-1:0] addr_en
);

  localparam int unsigned CNT_W = CHIP_W + ROW_W + COL_W;

  prog_state_e                    state_q, state_d;
  logic                           start_q;
  logic                           armed_q;
  logic                           ready_q, ready_d;
  logic [CHIP_W-1:0]              chip_q, chip_d;
  logic [ROW_W-1:0]               row_q, row_d;
  logic [COL_W-1:0]               col_q, col_d;
  logic [NUM_CHIPS_PER_CHAIN-1:0] en_q, en_d;
  logic                           start_rise;
  logic                           last_cell;

  // armed_q blocks a start level that is already high when reset releases
  assign start_rise = start_prog & ~start_q & armed_q;
  assign last_cell  = (chip_q == CHIP_W'(NUM_CHIPS_PER_CHAIN - 1)) & (&row_q) & (&col_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PROG_IDLE;
      start_q <= 1'b0;
      armed_q <= 1'b0;
      ready_q <= 1'b1;
      chip_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_prog;
      armed_q <= 1'b1;
      ready_q <= ready_d;
      chip_q  <= chip_d;
      row_q   <= row_d;
      col_q   <= col_d;
      en_q    <= en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    chip_d  = chip_q;
    row_d   = row_q;
    col_d   = col_q;
    en_d    = '0;
    case (state_q)
      PROG_IDLE: begin
        if (start_rise) begin
          state_d = PROG_SET;
          ready_d = 1'b0;
        end
      end
      PROG_SET:  state_d = PROG_WAIT;
      PROG_WAIT: begin
        state_d = PROG_STROBE;
        en_d    = NUM_CHIPS_PER_CHAIN'(1) << chip_q;
      end
      PROG_STROBE: state_d = PROG_HOLD;
      PROG_HOLD: begin
        if (last_cell) begin
          state_d = PROG_IDLE;
          ready_d = 1'b1;
          chip_d  = '0;
          row_d   = '0;
          col_d   = '0;
        end else begin
          state_d = PROG_SET;
          {chip_d, row_d, col_d} = CNT_W'({chip_q, row_q, col_q} + 1'b1);
        end
      end
      default: begin
        state_d = PROG_IDLE;
        ready_d = 1'b1;
        chip_d  = '0;
        row_d   = '0;
        col_d   = '0;
      end
    endcase
  end

  assign ready_prog         = ready_q;
  assign row_addr           = row_q;
  assign col_addr           = col_q;
  assign chip_in_chain_addr = chip_q;
  assign addr_en            = en_q;

endmodule

// File: rtl/scan_chain.sv
// Readout sequencer: one spin-capture pulse, then capture/shift of every scan bit
// into the result BRAM at bit_addr.
module scan_chain
  import cobi_pkg::*;
#(
  parameter int unsigned SCAN_CHAIN_DEPTH = 1008,
  localparam int unsigned BIT_W = (SCAN_CHAIN_DEPTH > 1) ? $clog2(SCAN_CHAIN_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_scan,
  output logic             ready_scan,
  output logic             sample_clk,
  output logic             scanout_clk,
  output logic             scan_chain_out_valid,
  output logic [BIT_W-1:0] bit_addr
);

  scan_state_e      state_q, state_d;
  logic             start_q;
  logic             armed_q;
  logic             ready_q, ready_d;
  logic             phase_q, phase_d;
  logic             samp_q, samp_d;
  logic             shift_q, shift_d;
  logic             valid_q, valid_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             start_rise;

  assign start_rise = start_scan & ~start_q & armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN_IDLE;
      start_q <= 1'b0;
      armed_q <= 1'b0;
      ready_q <= 1'b1;
      phase_q <= 1'b0;
      samp_q  <= 1'b0;
      shift_q <= 1'b0;
      valid_q <= 1'b0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_scan;
      armed_q <= 1'b1;
      ready_q <= ready_d;
      phase_q <= phase_d;
      samp_q  <= samp_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      bit_q   <= bit_d;
    end
  end

  // phase_q stretches the sample clock high and low phases to two cycles each
  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    phase_d = 1'b0;
    samp_d  = 1'b0;
    shift_d = 1'b0;
    valid_d = 1'b0;
    bit_d   = bit_q;
    case (state_q)
      SCAN_IDLE: begin
        if (start_rise) begin
          state_d = SCAN_SAMP_HI;
          ready_d = 1'b0;
          samp_d  = 1'b1;
        end
      end
      SCAN_SAMP_HI: begin
        if (!phase_q) begin
          phase_d = 1'b1;
          samp_d  = 1'b1;
        end else begin
          state_d = SCAN_SAMP_LO;
        end
      end
      SCAN_SAMP_LO: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          state_d = SCAN_CAPT;
          valid_d = 1'b1;
        end
      end
      SCAN_CAPT: begin
        if (bit_q == BIT_W'(SCAN_CHAIN_DEPTH - 1)) begin
          state_d = SCAN_IDLE;
          ready_d = 1'b1;
          bit_d   = '0;
        end else begin
          state_d = SCAN_SH_HI;
          shift_d = 1'b1;
          bit_d   = BIT_W'(bit_q + 1'b1);
        end
      end
      SCAN_SH_HI: state_d = SCAN_SH_LO;
      SCAN_SH_LO: begin
        state_d = SCAN_CAPT;
        valid_d = 1'b1;
      end
      default: begin
        state_d = SCAN_IDLE;
        ready_d = 1'b1;
        bit_d   = '0;
      end
    endcase
  end

  assign ready_scan           = ready_q;
  assign sample_clk           = samp_q;
  assign scanout_clk          = shift_q;
  assign scan_chain_out_valid = valid_q;
  assign bit_addr             = bit_q;

endmodule

// File: rtl/cobi_interface.sv
// Host-side COBI chain sequencer: independent weight-programming and scan-readout engines.
module cobi_interface
  import cobi_pkg::*;
#(
  parameter int unsigned NUM_CHIPS_PER_CHAIN = 2,
  parameter int unsigned SCAN_CHAIN_DEPTH    = BITS_PER_CHIP * NUM_CHIPS_PER_CHAIN,
  localparam int unsigned CHIP_W = chip_addr_w(NUM_CHIPS_PER_CHAIN),
  localparam int unsigned BIT_W  = (SCAN_CHAIN_DEPTH > 1) ? $clog2(SCAN_CHAIN_DEPTH) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_prog,
  output logic                           ready_prog,
  output logic [ROW_W-1:0]               row_addr,
  output logic [COL_W-1:0]               col_addr,
  output logic [CHIP_W-1:0]              chip_in_chain_addr,
  output logic [NUM_CHIPS_PER_CHAIN-1:0] addr_en,
  input  logic                           start_scan,
  output logic                           ready_scan,
  output logic                           sample_clk,
  output logic                           scanout_clk,
  output logic                           scan_chain_out_valid,
  output logic [BIT_W-1:0]               bit_addr
);

  programming #(
    .NUM_CHIPS_PER_CHAIN(NUM_CHIPS_PER_CHAIN)
  ) u_programming (
    .clk               (clk),
    .rst_n             (rst_n),
    .start_prog        (start_prog),
    .ready_prog        (ready_prog),
    .row_addr          (row_addr),
    .col_addr          (col_addr),
    .chip_in_chain_addr(chip_in_chain_addr),
    .addr_en           (addr_en)
  );

  scan_chain #(
    .SCAN_CHAIN_DEPTH(SCAN_CHAIN_DEPTH)
  ) u_scan_chain (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start_scan          (start_scan),
    .ready_scan          (ready_scan),
    .sample_clk          (sample_clk),
    .scanout_clk         (scanout_clk),
    .scan_chain_out_valid(scan_chain_out_valid),
    .bit_addr            (bit_addr)
  );

endmodule

// File: tb/tb_cobi_interface.sv
// Scoreboard bench for cobi_interface with a weight BRAM, chip weight store and scan chain model.
module tb_cobi_interface;
  import cobi_pkg::*;

  localparam int unsigned N        = 2;
  localparam int unsigned DEPTH    = BITS_PER_CHIP * N;
  localparam int unsigned CW       = chip_addr_w(N);
  localparam int unsigned BW       = $clog2(DEPTH);
  localparam int unsigned WW       = 8;
  localparam int unsigned CELLS    = 4096;
  localparam int unsigned PROG_CYC = 4 * CELLS * N;
  localparam int unsigned SCAN_CYC = 4 + 3 * (DEPTH - 1) + 1;

  logic          clk;
  logic          rst_n;
  logic          start_prog;
  logic          ready_prog;
  logic [5:0]    row_addr;
  logic [5:0]    col_addr;
  logic [CW-1:0] chip_in_chain_addr;
  logic [N-1:0]  addr_en;
  logic          start_scan;
  logic          ready_scan;
  logic          sample_clk;
  logic          scanout_clk;
  logic          scan_chain_out_valid;
  logic [BW-1:0] bit_addr;

  cobi_interface #(.NUM_CHIPS_PER_CHAIN(N)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start_prog          (start_prog),
    .ready_prog          (ready_prog),
    .row_addr            (row_addr),
    .col_addr            (col_addr),
    .chip_in_chain_addr  (chip_in_chain_addr),
    .addr_en             (addr_en),
    .start_scan          (start_scan),
    .ready_scan          (ready_scan),
    .sample_clk          (sample_clk),
    .scanout_clk         (scanout_clk),
    .scan_chain_out_valid(scan_chain_out_valid),
    .bit_addr            (bit_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Weight BRAM (1-cycle read) and the chips' weight stores
  logic [WW-1:0] wbram  [N*CELLS];
  logic [WW-1:0] chip_w [N*CELLS];
  logic [WW-1:0] wdout;

  always @(posedge clk) begin
    wdout <= wbram[{chip_in_chain_addr, row_addr, col_addr}];
    for (int c = 0; c < int'(N); c++)
      if (addr_en[c]) chip_w[c*CELLS + int'(row_addr)*64 + int'(col_addr)] <= wdout;
  end

  // Scan chain: capture spins on sample_clk rise, shift toward bit 0 on scanout_clk rise
  logic [DEPTH-1:0] spins;
  logic [DEPTH-1:0] sr;
  logic [DEPTH-1:0] res_bram;
  logic             samp_p, shft_p;

  always @(posedge clk) begin
    samp_p <= sample_clk;
    shft_p <= scanout_clk;
    if (sample_clk && !samp_p) sr <= spins;
    else if (scanout_clk && !shft_p) sr <= sr >> 1;
    if (scan_chain_out_valid) res_bram[bit_addr] <= sr[0];
  end

  typedef struct packed {
    logic [CW-1:0] chip;
    logic [5:0]    row;
    logic [5:0]    col;
    logic [N-1:0]  en;
  } prog_exp_t;

  typedef struct packed {
    logic [BW-1:0] addr;
    logic          b;
  } scan_exp_t;

  prog_exp_t prog_q[$];
  scan_exp_t scan_q[$];
  int        prog_len_q[$];
  int        scan_len_q[$];
  int        strobes, samp_pulses, shift_pulses;
  int        prog_len, scan_len;
  logic      samp_n, shft_n;

  task automatic push_prog();
    prog_exp_t e;
    for (int c = 0; c < int'(N); c++)
      for (int r = 0; r < 64; r++)
        for (int k = 0; k < 64; k++) begin
          e.chip = CW'(c);
          e.row  = 6'(r);
          e.col  = 6'(k);
          e.en   = N'(1 << c);
          prog_q.push_back(e);
        end
  endtask

  task automatic push_scan();
    scan_exp_t e;
    for (int i = 0; i < int'(DEPTH); i++) begin
      e.addr = BW'(i);
      e.b    = spins[i];
      scan_q.push_back(e);
    end
  endtask

  // Monitor: pops expected strobes/captures and measures busy lengths and pulses
  initial begin
    strobes = 0; samp_pulses = 0; shift_pulses = 0;
    prog_len = 0; scan_len = 0; samp_n = 1'b0; shft_n = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (addr_en != '0) begin
          strobes++;
          if (prog_q.size() == 0) check("unexpected_strobe", longint'(addr_en), 0);
          else check("prog_strobe", longint'({chip_in_chain_addr, row_addr, col_addr, addr_en}),
                     longint'(prog_q.pop_front()));
        end
        if (scan_chain_out_valid) begin
          if (scan_q.size() == 0) check("unexpected_capture", longint'(bit_addr), -1);
          else check("scan_capture", longint'({bit_addr, sr[0]}), longint'(scan_q.pop_front()));
        end
        if (sample_clk && !samp_n) samp_pulses++;
        if (scanout_clk && !shft_n) shift_pulses++;
        if (!ready_prog) prog_len++;
        else if (prog_len != 0) begin prog_len_q.push_back(prog_len); prog_len = 0; end
        if (!ready_scan) scan_len++;
        else if (scan_len != 0) begin scan_len_q.push_back(scan_len); scan_len = 0; end
      end else begin
        prog_len = 0;
        scan_len = 0;
      end
      samp_n = sample_clk;
      shft_n = scanout_clk;
    end
  end

  task automatic randomize_weights();
    for (int i = 0; i < int'(N*CELLS); i++) wbram[i] = WW'($urandom);
  endtask

  task automatic randomize_spins();
    for (int i = 0; i < int'(DEPTH); i++) spins[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_ready(input bit prog, input int budget);
    for (int i = 0; i < budget && !(prog ? ready_prog : ready_scan); i++) @(negedge clk);
    check(prog ? "prog_timeout" : "scan_timeout", prog ? ready_prog : ready_scan, 1);
    @(negedge clk);
  endtask

  task automatic check_prog_done(input int strobes0);
    int mism;
    if (prog_len_q.size() == 0) check("prog_busy_len", 0, PROG_CYC);
    else check("prog_busy_len", prog_len_q.pop_front(), PROG_CYC);
    check("prog_strobe_count", strobes - strobes0, N*CELLS);
    check("prog_queue_left", prog_q.size(), 0);
    for (int c = 0; c < int'(N); c++) begin
      mism = 0;
      for (int i = 0; i < int'(CELLS); i++)
        if (chip_w[c*CELLS + i] !== wbram[c*CELLS + i]) mism++;
      check($sformatf("chip%0d_weights", c), mism, 0);
    end
  endtask

  task automatic check_scan_done(input int samp0, input int shift0);
    if (scan_len_q.size() == 0) check("scan_busy_len", 0, SCAN_CYC);
    else check("scan_busy_len", scan_len_q.pop_front(), SCAN_CYC);
    check("sample_pulses", samp_pulses - samp0, 1);
    check("shift_pulses", shift_pulses - shift0, DEPTH - 1);
    check("scan_queue_left", scan_q.size(), 0);
    check("result_bram_ne_spins", longint'(res_bram != spins), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready_prog"}, ready_prog, 1);
    check({tag, "_ready_scan"}, ready_scan, 1);
    check({tag, "_addr_en"}, addr_en, 0);
    check({tag, "_addrs"}, longint'({chip_in_chain_addr, row_addr, col_addr}), 0);
    check({tag, "_sample_clk"}, sample_clk, 0);
    check({tag, "_scanout_clk"}, scanout_clk, 0);
    check({tag, "_valid"}, scan_chain_out_valid, 0);
    check({tag, "_bit_addr"}, bit_addr, 0);
  endtask

  int s0, p0, h0;

  initial begin
    rst_n = 1'b0;
    start_prog = 1'b0;
    start_scan = 1'b0;
    randomize_weights();
    randomize_spins();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");

    // Start already high when reset releases: no run
    start_scan = 1'b1;
    start_prog = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("no_run_after_reset_scan", ready_scan, 1);
    check("no_run_after_reset_prog", ready_prog, 1);
    start_scan = 1'b0;
    start_prog = 1'b0;
    repeat (3) @(negedge clk);

    // Programming alone; level held 50 cycles and a second edge while busy
    s0 = strobes;
    push_prog();
    start_prog = 1'b1;
    @(negedge clk);
    check("prog_ready_drops", ready_prog, 0);
    repeat (49) @(negedge clk);
    start_prog = 1'b0;
    repeat ($urandom_range(10, 200)) @(negedge clk);
    start_prog = 1'b1;
    repeat (3) @(negedge clk);
    start_prog = 1'b0;
    wait_ready(1'b1, PROG_CYC + 50);
    check_prog_done(s0);
    repeat (20) @(negedge clk);
    check("prog_single_run", ready_prog, 1);
    check("prog_no_extra_strobes", strobes - s0, N*CELLS);

    // Scan alone with random pulse width
    randomize_spins();
    p0 = samp_pulses; h0 = shift_pulses;
    push_scan();
    start_scan = 1'b1;
    @(negedge clk);
    check("scan_ready_drops", ready_scan, 0);
    repeat ($urandom_range(0, 40)) @(negedge clk);
    start_scan = 1'b0;
    wait_ready(1'b0, SCAN_CYC + 50);
    check_scan_done(p0, h0);

    // Reset mid-scan at bit 100, then a full restart
    randomize_spins();
    push_scan();
    start_scan = 1'b1;
    @(negedge clk);
    start_scan = 1'b0;
    for (int i = 0; i < 1000 && !(scan_chain_out_valid && bit_addr == BW'(100)); i++) @(negedge clk);
    check("reached_bit100", longint'(bit_addr), 100);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midscan_reset");
    scan_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    randomize_spins();
    p0 = samp_pulses; h0 = shift_pulses;
    push_scan();
    start_scan = 1'b1;
    @(negedge clk);
    start_scan = 1'b0;
    check("restart_bit_addr", bit_addr, 0);
    wait_ready(1'b0, SCAN_CYC + 50);
    check_scan_done(p0, h0);

    // Concurrent starts on the same cycle
    randomize_weights();
    randomize_spins();
    s0 = strobes; p0 = samp_pulses; h0 = shift_pulses;
    push_prog();
    push_scan();
    start_prog = 1'b1;
    start_scan = 1'b1;
    @(negedge clk);
    check("conc_prog_busy", ready_prog, 0);
    check("conc_scan_busy", ready_scan, 0);
    repeat ($urandom_range(1, 20)) @(negedge clk);
    start_prog = 1'b0;
    start_scan = 1'b0;
    wait_ready(1'b0, SCAN_CYC + 50);
    check_scan_done(p0, h0);
    check("conc_prog_still_busy", ready_prog, 0);
    wait_ready(1'b1, PROG_CYC + 50);
    check_prog_done(s0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
